// File: rtl/sram_fifo_pkg.sv
// Shared sizing and types for the SRAM2RW32x33-backed FIFO controller.
// SRAM_FIFO_PARITY_EN reserves the top SRAM bit for even parity over the data word.
package sram_fifo_pkg;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int WORD_W = 33;
    localparam int LVL_W  = 6;
`ifdef SRAM_FIFO_PARITY_EN
    localparam int DATA_W = WORD_W - 1;
`else
    localparam int DATA_W = WORD_W;
`endif

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W:0]   ptr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    function automatic logic even_par(input data_t d);
        return ^d;
    endfunction
endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry skid buffer that absorbs the SRAM's registered read so the
// consumer side can sustain one word per cycle.
module sram_fifo_outbuf #(
    parameter int W = 33
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [1:0]   cnt_o,
    output logic         valid_o,
    output logic [W-1:0] head_o
);
    logic [1:0][W-1:0] slot_q;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q ^ push_i;
        rd_d  = rd_q ^ pop_i;
        cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // Slot contents survive a flush; only the occupancy is cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= 2'd0;
        end else if (flush_i) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_i)
                slot_q[wr_q] <= push_data_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign valid_o = (cnt_q != 2'd0);
    assign head_o  = slot_q[rd_q];
endmodule

// File: rtl/sram2rw_fifo_ctrl.sv
// Runs one SRAM2RW32x33 as a 32-deep FIFO: port 1 enqueues, port 2 dequeues.
// Optional SRAM_FIFO_PARITY_EN stores even parity in the top bit and flags mismatches on perr.
module sram2rw_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  data_t            in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output data_t            out_data,
    output logic [LVL_W-1:0] level,
    output addr_t            sram_a1,
    output logic             sram_csb1,
    output logic             sram_web1,
    output logic             sram_oeb1,
    output word_t            sram_i1,
    output addr_t            sram_a2,
    output logic             sram_csb2,
    output logic             sram_web2,
    output logic             sram_oeb2,
    input  word_t            sram_o2
`ifdef SRAM_FIFO_PARITY_EN
    ,
    output logic             perr
`endif
);
    ptr_t       wptr_q, wptr_d;
    ptr_t       rptr_q, rptr_d;
    logic       rd_inflight_q, rd_inflight_d;
    ptr_t       mem_cnt;
    logic [1:0] ob_cnt;
    logic [2:0] ob_pend;
    logic       wr_en, rd_en, pop;

    assign mem_cnt = wptr_q - rptr_q;

    // Holding in_ready low while in reset keeps port 1 idle until reset_n releases.
    assign in_ready = reset_n && !flush && (mem_cnt < ptr_t'(DEPTH));
    assign wr_en    = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Buffer slots already claimed after this cycle's pop; a read may only claim a free one.
    assign ob_pend = {1'b0, ob_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop};
    assign rd_en   = !flush && (mem_cnt != '0) && (ob_pend < 3'd2);

    always_comb begin
        wptr_d        = wptr_q + ptr_t'(wr_en);
        rptr_d        = rptr_q + ptr_t'(rd_en);
        rd_inflight_d = rd_en;
        if (flush) begin
            wptr_d        = '0;
            rptr_d        = '0;
            rd_inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    assign sram_a1   = wptr_q[ADDR_W-1:0];
    assign sram_csb1 = !wr_en;
    assign sram_web1 = !wr_en;
    assign sram_oeb1 = 1'b1;
    assign sram_a2   = rptr_q[ADDR_W-1:0];
    assign sram_csb2 = !rd_en;
    assign sram_web2 = 1'b1;
    assign sram_oeb2 = !rd_en;

`ifdef SRAM_FIFO_PARITY_EN
    logic perr_q, perr_d;

    assign sram_i1 = {even_par(in_data), in_data};

    always_comb begin
        perr_d = perr_q;
        if (flush)
            perr_d = 1'b0;
        else if (rd_inflight_q && (^sram_o2))
            perr_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            perr_q <= 1'b0;
        else
            perr_q <= perr_d;
    end

    assign perr = perr_q;
`else
    assign sram_i1 = in_data;
`endif

    sram_fifo_outbuf #(.W(DATA_W)) u_outbuf (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush_i     (flush),
        .push_i      (rd_inflight_q),
        .push_data_i (sram_o2[DATA_W-1:0]),
        .pop_i       (pop),
        .cnt_o       (ob_cnt),
        .valid_o     (out_valid),
        .head_o      (out_data)
    );

    assign level = LVL_W'(mem_cnt) + LVL_W'(rd_inflight_q) + LVL_W'(ob_cnt);
endmodule
